// File: rtl/i2s_audio_tx.sv
// Philips-I2S transmitter: buffers stereo PCM frames in a small FIFO and serializes them
// MSB first with the one-bit I2S delay, muting and flushing while the PLL is unlocked.
module i2s_audio_tx #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pll_locked,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  output logic                          lrck,
  output logic                          sdata,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned FrameW = 2 * SAMPLE_W;
  localparam int unsigned CntW   = $clog2(FrameW);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;

  logic              lk_meta_q, lk_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [CntW-1:0]   bit_idx;
  logic [FrameW-1:0] w_q;
  logic              underrun_q;
  logic [FrameW-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              slot_edge, push, pop, fifo_empty;

  assign fifo_empty = (level_q == '0);
  assign slot_edge  = lk_q && (bit_cnt_q == '0);
  assign s_ready    = lk_q && (level_q < LvlW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  // Pop decision uses the pre-edge level, so a same-cycle push cannot satisfy it.
  assign pop        = slot_edge && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta_q  <= 1'b0;
      lk_q       <= 1'b0;
      bit_cnt_q  <= '0;
      w_q        <= '0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
      if (!lk_q) begin
        bit_cnt_q  <= '0;
        w_q        <= '0;
        underrun_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
      end else begin
        bit_cnt_q  <= bit_cnt_q + 1'b1;
        underrun_q <= slot_edge && fifo_empty;
        if (slot_edge) begin
          w_q <= pop ? mem[rd_ptr_q] : '0;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s_left, s_right};
    end
  end

  // Index -n mod 32: n=1 selects W[31]; n=0 selects the still-held previous W[0].
  assign bit_idx = '0 - bit_cnt_q;

  always_comb begin
    lrck        = lk_q & bit_cnt_q[CntW-1];
    frame_start = lk_q & (bit_cnt_q == '0);
    sdata       = lk_q & w_q[bit_idx];
    underrun    = lk_q & underrun_q;
    fifo_level  = lk_q ? level_q : '0;
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: stimulus queues expected frames, a negedge monitor
// deserializes each I2S slot and compares it against the queue.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        rst, pll_locked, s_valid, s_ready;
  logic [15:0] s_left, s_right;
  logic        lrck, sdata, frame_start, underrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {underrun, word}
  bit mon_en = 1'b0;

  i2s_audio_tx #(.SAMPLE_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .lrck(lrck), .sdata(sdata), .frame_start(frame_start), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic wait_frame_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_timeout: got no frame_start required one within 40 cycles");
    end
  endtask

  task automatic push_frame(input logic [31:0] w);
    int n = 0;
    s_valid = 1'b1;
    {s_left, s_right} = w;
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: got s_ready=%b required 1 within 100 cycles", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Monitor: deserialize n=1..31 plus next n=0, compare with the scoreboard head.
  int          idx = 0;
  bit          in_frame = 1'b0;
  logic [30:0] shreg;
  logic        ur;
  logic [31:0] got;
  logic [32:0] req;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 1'b0;
    end else if (frame_start === 1'b1) begin
      if (in_frame && idx == 31) begin
        got = {shreg, sdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got word %h underrun %b required no frame", got, ur);
        end else begin
          req = exp_q.pop_front();
          if ({ur, got} !== req) begin
            errors++;
            $display("FAIL frame: got word %h underrun %b required word %h underrun %b",
                     got, ur, req[31:0], req[32]);
          end
        end
      end
      checks++;
      if (lrck !== 1'b0) begin
        errors++;
        $display("FAIL lrck_n0: got %b required 0", lrck);
      end
      in_frame = 1'b1;
      idx = 0;
      shreg = '0;
    end else if (in_frame) begin
      idx++;
      shreg = {shreg[29:0], sdata};
      if (idx == 1) ur = underrun;
      else begin
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL underrun_n%0d: got %b required 0", idx, underrun);
        end
      end
      checks++;
      if (lrck !== (idx >= 16)) begin
        errors++;
        $display("FAIL lrck_n%0d: got %b required %b", idx, lrck, idx >= 16);
      end
      if (idx > 31) begin
        errors++;
        $display("FAIL frame_start_missing: got none required one after n=31");
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    repeat (3) @(negedge clk);
    chk("rst_lrck", 32'(lrck), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    rst = 1'b0; pll_locked = 1'b1; mon_en = 1'b1;

    // First slot after lock: push lands in the n=0 cycle, so it underruns.
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 32'hA55A_0F0F});
    push_frame(32'hA55A_0F0F);
    chk("n0push_underrun", 32'(underrun), 1);
    chk("n0push_level1", 32'(fifo_level), 1);
    wait_frame_start();
    @(negedge clk);
    chk("slot2_level0", 32'(fifo_level), 0);
    chk("slot2_no_underrun", 32'(underrun), 0);

    // Five back-to-back pushes: fourth fills the FIFO, fifth waits for the next pop.
    push_frame(32'h1234_5678);
    push_frame(32'h8000_0001);
    push_frame(32'hFFFF_0000);
    push_frame(32'h0001_FFFE);
    chk("full_level", 32'(fifo_level), 4);
    chk("full_s_ready", 32'(s_ready), 0);
    push_frame(32'hDEAD_BEEF);
    chk("refill_level", 32'(fifo_level), 4);
    exp_q.push_back({1'b0, 32'h1234_5678});
    exp_q.push_back({1'b0, 32'h8000_0001});
    exp_q.push_back({1'b0, 32'hFFFF_0000});
    exp_q.push_back({1'b0, 32'h0001_FFFE});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    repeat (7) wait_frame_start();
    chk("empty_level0", 32'(fifo_level), 0);

    // Queue three frames, then drop lock mid-frame.
    push_frame(32'h1111_2222);
    push_frame(32'h3333_4444);
    push_frame(32'h5555_6666);
    chk("three_queued", 32'(fifo_level), 3);
    repeat (15) @(negedge clk);
    pll_locked = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("unlock_lrck", 32'(lrck), 0);
    chk("unlock_sdata", 32'(sdata), 0);
    chk("unlock_frame_start", 32'(frame_start), 0);
    chk("unlock_level", 32'(fifo_level), 0);
    chk("unlock_s_ready", 32'(s_ready), 0);
    chk("unlock_drained_sb", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Relock: first slot underruns because the FIFO was flushed.
    pll_locked = 1'b1; mon_en = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 32'hC3C3_3C3C});
    wait_frame_start();
    @(negedge clk);
    push_frame(32'hC3C3_3C3C);
    wait_frame_start();
    @(negedge clk);
    push_frame(32'h7FFF_8000);
    push_frame(32'h5555_AAAA);
    wait_frame_start();
    repeat (20) @(negedge clk);

    // Synchronous reset at n=20 discards the partial frame and the queue.
    mon_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst20_lrck", 32'(lrck), 0);
    chk("rst20_sdata", 32'(sdata), 0);
    chk("rst20_frame_start", 32'(frame_start), 0);
    chk("rst20_underrun", 32'(underrun), 0);
    chk("rst20_level", 32'(fifo_level), 0);
    chk("rst20_s_ready", 32'(s_ready), 0);
    rst = 1'b0; mon_en = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    wait_frame_start();
    wait_frame_start();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
